// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: picorv32 native-bus slice seen by the 7-segment driver.
// master = CPU/address decode side, slave = seg7_scan_ctrl.
interface seg7_scan_ctrl_if;
  logic        sel;
  logic        mem_valid;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output sel,
    output mem_valid,
    output mem_wstrb,
    output mem_wdata,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  sel,
    input  mem_valid,
    input  mem_wstrb,
    input  mem_wdata,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: memory-mapped 2-digit multiplexed 7-segment scanner.
// Define SEG7_PWM_EN to add 4-bit PWM brightness (CTRL[15:12]).
module seg7_scan_ctrl #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int SCAN_HZ     = 1000,
  parameter int DEAD        = 8,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit COM_ACT_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  seg7_scan_ctrl_if.slave     bus,
  output logic [7:0]          SEG_o,
  output logic [1:0]          COM_o
);

  localparam int PERIOD = CLK_HZ / SCAN_HZ;
  localparam int CW     = (PERIOD > 2) ? $clog2(PERIOD) : 1;

  localparam logic [CW-1:0] CNT_MAX = CW'(PERIOD - 1);
  localparam logic [CW-1:0] DEAD_C  = CW'(DEAD);
  localparam logic [11:0]   CTRL_RST = 12'hC00;

  localparam logic [7:0] SEG_OFF = {8{SEG_ACT_LOW}};
  localparam logic [1:0] COM_OFF = {2{COM_ACT_LOW}};

  logic          acked;
  logic          hit;
  logic          ack;
  logic [11:0]   ctrl_lo;
  logic [11:0]   shadow_lo;
  logic [3:0]    bright;
  logic [3:0]    shadow_bright;
  logic [31:0]   ctrl_word;
  logic [CW-1:0] cnt;
  logic          digit;
  logic          gate;
  logic [3:0]    hex;
  logic          dp;
  logic          blank;
  logic          lit;
  logic [6:0]    font;

  // A held request is acknowledged once; acked clears when it drops.
  assign hit = bus.sel & bus.mem_valid;
  assign ack = hit & ~bus.mem_ready & ~acked;

  assign ctrl_word = {16'h0, bright, ctrl_lo};

  // Bus handshake, read data and CTRL byte writes
  always_ff @(posedge clk) begin
    if (reset) begin
      acked         <= 1'b0;
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= 32'h0;
      ctrl_lo       <= CTRL_RST;
    end else begin
      acked         <= hit & (acked | ack);
      bus.mem_ready <= ack;
      bus.mem_rdata <= ack ? ctrl_word : 32'h0;
      if (ack && bus.mem_wstrb[0])
        ctrl_lo[7:0] <= bus.mem_wdata[7:0];
      if (ack && bus.mem_wstrb[1])
        ctrl_lo[11:8] <= bus.mem_wdata[11:8];
    end
  end

`ifdef SEG7_PWM_EN
  logic [3:0] pwm;
  logic       unused_bus;

  assign unused_bus = ^{bus.mem_wdata[31:16], bus.mem_wstrb[3:2]};

  // Brightness nibble lives beside the other CTRL bits
  always_ff @(posedge clk) begin
    if (reset)
      bright <= 4'h0;
    else if (ack && bus.mem_wstrb[1])
      bright <= bus.mem_wdata[15:12];
  end

  // Free-running PWM phase
  always_ff @(posedge clk) begin
    if (reset)
      pwm <= 4'h0;
    else
      pwm <= pwm + 4'h1;
  end

  assign gate = (pwm <= shadow_bright);
`else
  logic unused_bus;

  assign unused_bus = ^{bus.mem_wdata[31:12], bus.mem_wstrb[3:2],
                        shadow_bright};
  assign bright = 4'h0;
  assign gate   = 1'b1;
`endif

  // Dwell counter; CTRL is sampled into the shadow only at a wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= '0;
      digit         <= 1'b0;
      shadow_lo     <= CTRL_RST;
      shadow_bright <= 4'h0;
    end else if (cnt == CNT_MAX) begin
      cnt           <= '0;
      digit         <= ~digit;
      shadow_lo     <= ctrl_lo;
      shadow_bright <= bright;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hex   = digit ? shadow_lo[7:4] : shadow_lo[3:0];
  assign dp    = digit ? shadow_lo[9]   : shadow_lo[8];
  assign blank = digit ? shadow_lo[11]  : shadow_lo[10];
  assign lit   = (cnt >= DEAD_C) & ~blank & gate;

  // Hex font, bit order g..a
  always_comb begin
    font = 7'h00;
    unique case (hex)
      4'h0: font = 7'h3F;
      4'h1: font = 7'h06;
      4'h2: font = 7'h5B;
      4'h3: font = 7'h4F;
      4'h4: font = 7'h66;
      4'h5: font = 7'h6D;
      4'h6: font = 7'h7D;
      4'h7: font = 7'h07;
      4'h8: font = 7'h7F;
      4'h9: font = 7'h6F;
      4'hA: font = 7'h77;
      4'hB: font = 7'h7C;
      4'hC: font = 7'h39;
      4'hD: font = 7'h5E;
      4'hE: font = 7'h79;
      4'hF: font = 7'h71;
    endcase
  end

  // Registered pins, polarity applied after decode
  always_ff @(posedge clk) begin
    if (reset) begin
      SEG_o <= SEG_OFF;
      COM_o <= COM_OFF;
    end else if (lit) begin
      SEG_o <= {dp, font} ^ SEG_OFF;
      COM_o <= (digit ? 2'b10 : 2'b01) ^ COM_OFF;
    end else begin
      SEG_o <= SEG_OFF;
      COM_o <= COM_OFF;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: randomized bus traffic against a history-based
// display model (PERIOD=16, DEAD=2, active-low pins).
module tb_seg7_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] seg;
  logic [1:0] com;

  seg7_scan_ctrl_if bus ();

  seg7_scan_ctrl #(
    .CLK_HZ(1600),
    .SCAN_HZ(100),
    .DEAD(2),
    .SEG_ACT_LOW(1'b1),
    .COM_ACT_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .SEG_o(seg),
    .COM_o(com)
  );

  always #5 clk = ~clk;

  int          n_err = 0;
  int          n_chk = 0;
  int          n = 0;
  bit          req_seen = 1'b0;
  logic [31:0] mctrl = 32'h0000_0C00;
  logic [31:0] hist[$];
  logic [6:0]  font_tbl[16];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  task automatic do_reset(input int cyc);
    reset = 1'b1;
    bus.sel = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'h0;
    bus.mem_wdata = 32'h0;
    repeat (cyc) begin
      @(posedge clk);
      #1;
      chk("rst_seg", {24'h0, seg}, 32'hFF);
      chk("rst_com", {30'h0, com}, 32'h3);
      chk("rst_rdy", {31'h0, bus.mem_ready}, 32'h0);
    end
    reset = 1'b0;
    n = 0;
    hist.delete();
    mctrl = 32'h0000_0C00;
    req_seen = 1'b0;
  endtask

  // One clock: model CTRL history, then check pins and bus outputs.
  task automatic tick();
    bit          hit;
    bit          first;
    logic [31:0] pre;
    logic [31:0] sh;
    logic [7:0]  hi;
    logic [7:0]  seg_exp;
    logic [1:0]  com_exp;
    int          idx, ph, d, dg;
    bit          on, gate;
    hit   = bus.sel && bus.mem_valid;
    first = hit && !req_seen;
    req_seen = hit ? (req_seen || first) : 1'b0;
    pre = mctrl;
    hist.push_back(mctrl);
    @(posedge clk);
    #1;
    n++;
    if (first) begin
      if (bus.mem_wstrb[0])
        mctrl[7:0] = bus.mem_wdata[7:0];
      if (bus.mem_wstrb[1]) begin
        hi = bus.mem_wdata[15:8];
`ifndef SEG7_PWM_EN
        hi[7:4] = 4'h0;
`endif
        mctrl[15:8] = hi;
      end
    end
    idx = n - 1;
    ph  = idx % 16;
    d   = idx / 16;
    dg  = d % 2;
    sh  = (d == 0) ? 32'h0000_0C00 : hist[16*d-1];
`ifdef SEG7_PWM_EN
    gate = (ph <= int'(sh[15:12]));
`else
    gate = 1'b1;
`endif
    on = (ph >= 2) && !sh[10+dg] && gate;
    if (on) begin
      seg_exp = ~{sh[8+dg], font_tbl[dg ? sh[7:4] : sh[3:0]]};
      com_exp = dg ? 2'b01 : 2'b10;
    end else begin
      seg_exp = 8'hFF;
      com_exp = 2'b11;
    end
    chk("seg", {24'h0, seg}, {24'h0, seg_exp});
    chk("com", {30'h0, com}, {30'h0, com_exp});
    chk("ready", {31'h0, bus.mem_ready}, {31'h0, first});
    chk("rdata", bus.mem_rdata, first ? pre : 32'h0);
  endtask

  task automatic xfer(input bit s, input logic [3:0] st,
                      input logic [31:0] wd, input int hold,
                      input int idle);
    bus.sel = s;
    bus.mem_valid = 1'b1;
    bus.mem_wstrb = st;
    bus.mem_wdata = wd;
    repeat (hold) tick();
    bus.sel = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'h0;
    bus.mem_wdata = 32'h0;
    repeat (1 + idle) tick();
  endtask

  task automatic sync(input int ph);
    while (n % 16 != ph) tick();
  endtask

  // Count cycles matching two {COM,SEG} pin patterns.
  task automatic win(input int len, input logic [9:0] p0,
                     input logic [9:0] p1, output int h0, output int h1);
    h0 = 0;
    h1 = 0;
    repeat (len) begin
      tick();
      if ({com, seg} == p0) h0++;
      if ({com, seg} == p1) h1++;
    end
  endtask

  int h0, h1, act;

  initial begin
    font_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    do_reset(3);

    // blanked after reset, then a read of the reset value
    repeat (40) tick();
    xfer(1'b1, 4'h0, 32'h0, 1, 0);

    // write held 5 cycles: single ack checked per tick
    xfer(1'b1, 4'b0011, 32'h0000_0021, 5, 1);
    sync(0);
    win(32, {2'b10, ~8'h06}, {2'b01, ~8'h5B}, h0, h1);
    chk("t2_dig0", h0, 14);
    chk("t2_dig1", h1, 14);

    // decimal points on both digits
    xfer(1'b1, 4'b0011, 32'h0000_0331, 2, 0);
    sync(0);
    win(32, {2'b10, ~8'h86}, {2'b01, ~8'hCF}, h0, h1);
    chk("t3_dig0", h0, 14);
    chk("t3_dig1", h1, 14);

    // right digit blanked
    xfer(1'b1, 4'b0011, 32'h0000_0401, 1, 2);
    sync(0);
    win(32, {2'b01, ~8'h3F}, {2'b10, ~8'h06}, h0, h1);
    chk("t4_left", h0, 14);
    chk("t4_right", h1, 0);

    // write on the wrap cycle
    sync(15);
    xfer(1'b1, 4'b0001, 32'h0000_0045, 1, 0);
    repeat (40) tick();

    // brightness
    xfer(1'b1, 4'b0011, 32'h0000_3021, 1, 0);
    xfer(1'b1, 4'h0, 32'h0, 2, 0);
    sync(0);
    act = 0;
    repeat (32) begin
      tick();
      if (com != 2'b11) act++;
    end
`ifdef SEG7_PWM_EN
    chk("t6_duty", act, 4);
`else
    chk("t6_duty", act, 28);
`endif

    // randomized traffic with occasional mid-dwell resets
    for (int i = 0; i < 250; i++) begin
      logic [3:0]  st;
      logic [31:0] wd;
      bit          s;
      if ($urandom_range(0, 24) == 0)
        do_reset($urandom_range(1, 3));
      s  = ($urandom_range(0, 9) != 0);
      st = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      wd = $urandom;
      xfer(s, st, wd, $urandom_range(1, 4), $urandom_range(0, 12));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
